// File: rtl/lsu_align_pkg.sv
// Shared encodings and small helpers for the lsu_align load/store alignment unit.
// Access sizes, FSM states and lane-width constants live here.
package lsu_align_pkg;

    localparam int LANE_BITS = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    // The reserved size code is folded into a word access before anything else sees it.
    function automatic size_e norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : size_e'(sz);
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [LANE_BITS-1:0] lane);
        case (sz)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != '0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [LANE_BITS-1:0] force_align(input size_e sz,
                                                         input logic [LANE_BITS-1:0] lane);
        case (sz)
            SZ_HALF: return {lane[1], 1'b0};
            SZ_WORD: return '0;
            default: return lane;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: inserts store data into an old word, and extracts
// and extends a loaded lane. One instance serves both the load and store paths.
module lsu_lane_merge
    import lsu_align_pkg::*;
(
    input  logic [31:0]          old_word_i,
    input  logic [31:0]          new_data_i,
    input  logic [LANE_BITS-1:0] lane_i,
    input  size_e                size_i,
    input  logic                 sext_i,
    output logic [31:0]          merged_o,
    output logic [31:0]          extract_o
);

    logic [LANE_BITS+2:0] byte_sh;
    logic [LANE_BITS+2:0] half_sh;
    logic [31:0]          lane_mask;
    logic [31:0]          ins_data;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;

    // Halfwords always sit on an even lane, so only lane[1] picks the half.
    assign byte_sh = {lane_i, 3'b000};
    assign half_sh = {lane_i[1], 4'b0000};
    assign byte_v  = old_word_i[byte_sh +: 8];
    assign half_v  = old_word_i[half_sh +: 16];

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        lane_mask = '1;
        ins_data  = new_data_i;
        case (size_i)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF << byte_sh;
                ins_data  = new_data_i << byte_sh;
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF << half_sh;
                ins_data  = new_data_i << half_sh;
            end
            default: ;
        endcase
        merged_o = (old_word_i & ~lane_mask) | (ins_data & lane_mask);
    end

    always_comb begin
        extract_o = old_word_i;
        case (size_i)
            SZ_BYTE: extract_o = {{24{sext_i & byte_v[7]}}, byte_v};
            SZ_HALF: extract_o = {{16{sext_i & half_v[15]}}, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between the CPU datapath and a word-only data RAM.
// Build option LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of force-aligning them.
module lsu_align
    import lsu_align_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  misalign,
    output logic                  mem_we,
    output logic [BUS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                 state_q, state_d;
    logic [BUS_WIDTH-1:0]   waddr_q, waddr_d;
    logic [LANE_BITS-1:0]   lane_q, lane_d;
    size_e                  size_q, size_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  old_q, old_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   misalign_q, misalign_d;

    size_e                  req_size;
    logic [LANE_BITS-1:0]   req_lane;
    logic [BUS_WIDTH-1:0]   req_waddr;
    logic                   req_bad;
    logic                   in_rmw;

    logic [DATA_WIDTH-1:0]  mg_old;
    logic [LANE_BITS-1:0]   mg_lane;
    size_e                  mg_size;
    logic [DATA_WIDTH-1:0]  mg_merged;
    logic [DATA_WIDTH-1:0]  mg_extract;

    logic                   unused_addr_hi;

    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:BUS_WIDTH+2];

    assign req_size  = norm_size(size);
    assign req_waddr = addr[BUS_WIDTH+1:2];
    assign in_rmw    = (state_q == ST_RMW);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_lane = addr[LANE_BITS-1:0];
    assign req_bad  = is_misaligned(req_size, addr[LANE_BITS-1:0]);
`else
    assign req_lane = force_align(req_size, addr[LANE_BITS-1:0]);
    assign req_bad  = 1'b0;
`endif

    // In RMW the lane logic works on the latched store; otherwise it serves the live load.
    assign mg_old  = in_rmw ? old_q  : mem_rdata;
    assign mg_lane = in_rmw ? lane_q : req_lane;
    assign mg_size = in_rmw ? size_q : req_size;

    lsu_lane_merge u_lane_merge (
        .old_word_i (mg_old),
        .new_data_i (wdata_q),
        .lane_i     (mg_lane),
        .size_i     (mg_size),
        .sext_i     (sext),
        .merged_o   (mg_merged),
        .extract_o  (mg_extract)
    );

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        lane_d     = lane_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        old_d      = old_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = req_waddr;
        mem_wdata  = wdata;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_bad) begin
                        misalign_d = 1'b1;
                    end else if (!wr) begin
                        rdata_d  = mg_extract;
                        rvalid_d = 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        mem_we = 1'b1;
                    end else begin
                        waddr_d = req_waddr;
                        lane_d  = req_lane;
                        size_d  = req_size;
                        wdata_d = wdata;
                        old_d   = mem_rdata;
                        state_d = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                mem_addr  = waddr_q;
                mem_wdata = mg_merged;
                mem_we    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A reset landing on the write cycle must not corrupt the RAM.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            waddr_q    <= '0;
            lane_q     <= '0;
            size_q     <= SZ_BYTE;
            wdata_q    <= '0;
            old_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            old_q      <= old_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a transaction-level model predicts every cycle's
// outputs, a compare process checks them, and literal values pin the model.
`timescale 1ns/1ps
module tb_lsu_align;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst_n, req, wr, sext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, rvalid, misalign, mem_we;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [5:0]  mem_addr;

    always #5 clk = ~clk;

    lsu_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .misalign  (misalign),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Bench-side data RAM with a preload port used only while the DUT is idle.
    logic [31:0] ram [64];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (mem_we)     ram[mem_addr] <= mem_wdata;
        else if (pl_en) ram[pl_addr]  <= pl_data;
    end
    assign mem_rdata = ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: expected RAM contents and per-cycle expected outputs.
    logic [31:0] ref_mem [64];
    bit          e_busy   [MAXC];
    bit          e_we     [MAXC];
    bit          e_rvalid [MAXC];
    bit          e_mis    [MAXC];
    bit          e_chkadr [MAXC];
    logic [5:0]  e_maddr  [MAXC];
    logic [31:0] e_wdata  [MAXC];
    logic [31:0] e_rdata  [MAXC];

    bit          s_ready  [MAXC];
    bit          s_we     [MAXC];
    bit          s_rvalid [MAXC];
    logic [31:0] s_mwdata [MAXC];
    logic [31:0] s_maddr  [MAXC];
    logic [31:0] s_rdata  [MAXC];

    bit chk_en = 1'b0;

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] sz, input bit sx);
        logic [31:0] v;
        case (sz)
            2'b00: begin
                v = (w >> (8 * lane)) & 32'h0000_00FF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (w >> (8 * lane)) & 32'h0000_FFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] lane, input logic [1:0] sz);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
        case (sz)
            2'b00: b[lane] = d[7:0];
            2'b01: begin
                b[lane]     = d[7:0];
                b[lane + 1] = d[15:8];
            end
            default: return d;
        endcase
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit m_misal(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b01) return a[0];
        if (sz[1])       return (a != 2'b00);
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            s_ready[cyc]  = ready;
            s_we[cyc]     = mem_we;
            s_rvalid[cyc] = rvalid;
            s_maddr[cyc]  = 32'(mem_addr);
            s_mwdata[cyc] = mem_wdata;
            s_rdata[cyc]  = rdata;
            check("ready",    32'(ready),    32'(!e_busy[cyc]));
            check("mem_we",   32'(mem_we),   32'(e_we[cyc]));
            check("rvalid",   32'(rvalid),   32'(e_rvalid[cyc]));
            check("misalign", 32'(misalign), 32'(e_mis[cyc]));
            if (e_chkadr[cyc]) check("mem_addr",  32'(mem_addr), 32'(e_maddr[cyc]));
            if (e_we[cyc])     check("mem_wdata", mem_wdata,      e_wdata[cyc]);
            if (e_rvalid[cyc]) check("rdata",     rdata,          e_rdata[cyc]);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        pl_en      = 1'b1;
        pl_addr    = 6'(w);
        pl_data    = v;
        ref_mem[w] = v;
        sync();
        pl_en = 1'b0;
    endtask

    // Drive one request, hold it while the model says the unit is busy, and record
    // what the accepted access must produce. n returns the acceptance cycle.
    task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] d, output int n);
        int         wi;
        logic [1:0] ln;
        bit         bad;
        wr = w; size = sz; sext = sx; addr = a; wdata = d; req = 1'b1;
        for (int k = 0; k < 4 && e_busy[cyc]; k++) sync();
        n   = cyc;
        bad = 1'b0;
        ln  = a[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        bad = m_misal(sz, a[1:0]);
`else
        if (sz == 2'b01) ln[0] = 1'b0;
        else if (sz[1])  ln = 2'b00;
`endif
        wi = int'(a[7:2]);
        if (bad) begin
            e_mis[n+1] = 1'b1;
        end else if (!w) begin
            e_chkadr[n]   = 1'b1;
            e_maddr[n]    = a[7:2];
            e_rvalid[n+1] = 1'b1;
            e_rdata[n+1]  = m_load(ref_mem[wi], ln, sz, sx);
        end else if (sz[1]) begin
            e_we[n]     = 1'b1;
            e_chkadr[n] = 1'b1;
            e_maddr[n]  = a[7:2];
            e_wdata[n]  = d;
            ref_mem[wi] = d;
        end else begin
            e_busy[n+1]   = 1'b1;
            e_we[n+1]     = 1'b1;
            e_chkadr[n+1] = 1'b1;
            e_maddr[n+1]  = a[7:2];
            e_wdata[n+1]  = m_store(ref_mem[wi], d, ln, sz);
            ref_mem[wi]   = e_wdata[n+1];
        end
        sync();
        req = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [1:0]  sz;
        bit          sx;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_tab [4];
    logic [31:0] b2b_val [4];

    initial begin
        int n, m, n0;
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
        addr = '0; wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        ld_tab[0] = '{32'h2, 2'b00, 1'b1, 32'hFFFF_FFFF};
        ld_tab[1] = '{32'h2, 2'b00, 1'b0, 32'h0000_00FF};
        ld_tab[2] = '{32'h2, 2'b01, 1'b1, 32'hFFFF_80FF};
        ld_tab[3] = '{32'h1, 2'b00, 1'b1, 32'h0000_007F};
        b2b_val[0] = 32'h0102_0304;
        b2b_val[1] = 32'h5566_7788;
        b2b_val[2] = 32'h9ABC_DEF0;
        b2b_val[3] = 32'hCAFE_F00D;

        preload(0, 32'h80FF_7F01);
        preload(1, 32'h1122_3344);
        preload(2, 32'h0000_0000);
        preload(3, 32'h0000_0000);
        for (int i = 0; i < 4; i++) preload(8 + i, b2b_val[i]);

        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready",    32'(ready),    32'd1);
        check("rst_rvalid",   32'(rvalid),   32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_rdata",    rdata,         32'd0);
        sync();

        // Word store followed by word load of the same address.
        issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEAD_BEEF, n);
        check("wst_we",   32'(s_we[n]), 32'd1);
        check("wst_addr", s_maddr[n],   32'd2);
        issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, n);
        @(negedge clk);
        check("wld_rvalid", 32'(rvalid), 32'd1);
        check("wld_rdata",  rdata,       32'hDEAD_BEEF);
        sync();

        // Byte store RMW with a load held behind it.
        issue(1'b1, 2'b00, 1'b0, 32'h06, 32'h0000_00AB, n);
        issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0, m);
        check("rmw_ready",  32'(s_ready[n+1]),  32'd0);
        check("rmw_we",     32'(s_we[n+1]),     32'd1);
        check("rmw_wdata",  s_mwdata[n+1],      32'h11AB_3344);
        check("held_early", 32'(s_rvalid[n+2]), 32'd0);
        @(negedge clk);
        check("held_rdata", rdata, 32'h11AB_3344);
        sync();

        // Signed and unsigned sub-word loads from word 0.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, ld_tab[i].sz, ld_tab[i].sx, ld_tab[i].a, 32'h0, n);
            @(negedge clk);
            check("ext_rdata", rdata, ld_tab[i].exp);
            sync();
        end

        // Misaligned word load and misaligned half store.
        issue(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, n);
        @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_pulse",  32'(misalign), 32'd1);
        check("mis_rvalid", 32'(rvalid),   32'd0);
        check("mis_we",     32'(s_we[n]),  32'd0);
`else
        check("fa_rvalid", 32'(rvalid), 32'd1);
        check("fa_rdata",  rdata,       32'h11AB_3344);
`endif
        sync();
        issue(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_FFFF, n);
        @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_st_pulse", 32'(misalign), 32'd1);
`else
        check("fa_st_wdata", mem_wdata, 32'hFFFF_7F01);
`endif
        sync();

        // Reset asserted on the RMW write cycle aborts the write.
        n = cyc;
        req = 1'b1; wr = 1'b1; size = 2'b01; sext = 1'b0; addr = 32'h0A; wdata = 32'h1234;
        e_busy[n+1] = 1'b1;
        sync();
        req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_we",    32'(mem_we), 32'd0);
        check("abort_ready", 32'(ready),  32'd0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready",    32'(ready),    32'd1);
        check("post_rst_rvalid",   32'(rvalid),   32'd0);
        check("post_rst_misalign", 32'(misalign), 32'd0);
        check("post_rst_rdata",    rdata,         32'd0);
        sync();
        issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, n);
        @(negedge clk);
        check("abort_ram", rdata, 32'hDEAD_BEEF);
        sync();

        // Four back-to-back word loads.
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, n0);
        for (int i = 1; i < 4; i++) issue(1'b0, 2'b10, 1'b0, 32'h20 + 32'(4 * i), 32'h0, n);
        @(negedge clk);
        sync();
        for (int i = 0; i < 4; i++) begin
            check("b2b_ready",  32'(s_ready[n0+i]),    32'd1);
            check("b2b_rvalid", 32'(s_rvalid[n0+1+i]), 32'd1);
            check("b2b_rdata",  s_rdata[n0+1+i],       b2b_val[i]);
        end

        // The bench RAM must match the model's view of memory.
        for (int i = 0; i < 12; i++) begin
            if (i < 4 || i >= 8) check("ram_final", ram[i], ref_mem[i]);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
